alu_seq_calc: RTL and testbench
===============================

Name: alu_seq_calc

Overview:
Sequential, width-parametrised ALU calculator for the Nexys board flow.
- Operands A and B and an opcode are entered one after another on a shared switch bus, each committed by an `enter` button press.
- The block registers the result and five status flags, then presents a 32-bit display word for the existing hex-to-seven-segment driver.
- It sits between the debounced board inputs and the display/LED outputs, and replaces the purely combinational switch-to-ALU wiring.

Parameters:
- N, 7, operand/result width in bits; legal range 2..28.
- OP_W, 3, opcode width; fixed encoding below.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  N  operand value from switches.
- op_sel  in  OP_W  opcode from switches.
- enter  in  1  debounced button level; the block detects the rising edge internally.
- result  out  N  registered ALU result.
- flags  out  5  registered flags {N,Z,C,V,P}.
- result_valid  out  1  high while in S_RES.
- state_out  out  2  current FSM state, for LEDs.
- display_value  out  32  word for the hex display driver.

Behaviour:
Reset is asynchronous and active-high. While reset is high:
- state = S_A; A, B, result = 0; flags = 5'b0; result_valid = 0.
- enter_q = 1, so a button held through reset must be released before it can count as a press.

Edge detection:
- enter_rise = enter & ~enter_q; enter_q is registered every cycle.
- Holding enter for any number of cycles produces exactly one advance.

FSM (encoding S_A=0, S_B=1, S_OP=2, S_RES=3). All actions occur on the clock edge where enter_rise=1:
- S_A: A <= data_in; go to S_B.
- S_B: B <= data_in; go to S_OP.
- S_OP: result/flags <= alu(A, B, op_sel); go to S_RES. Latency is one clock from the enter_rise sample; result_valid rises in the same cycle that state becomes S_RES.
- S_RES: go to S_A. A, B, result and flags hold until overwritten.
- Without enter_rise, the state and all registers hold. Changes on data_in or op_sel have no effect on stored values.

Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1 (shift A left by 1), 6 SHR1 (logical shift A right by 1), 7 NOT A.

Flags:
- ADD: C = carry out of A+B (N+1-bit sum); V = (A[N-1]==B[N-1]) && (R[N-1]!=A[N-1]).
- SUB: R = A+~B+1; C = carry out, i.e. 1 when A>=B unsigned; V = (A[N-1]!=B[N-1]) && (R[N-1]!=A[N-1]).
- SHL1: C = A[N-1]. SHR1: C = A[0]. V = 0 for both.
- AND, OR, XOR, NOT: C = V = 0.
- All ops: N = R[N-1]; Z = (R==0); P = 1 when R has an even number of ones.

display_value:
- [31:28] = {2'b00, state}; [27:N] = 0.
- [N-1:0] = data_in live in S_A and S_B; zero-extended op_sel in S_OP; result in S_RES.

Reset mid-sequence: immediate return to S_A with all registers cleared. Any partial entry is discarded.

Optional Feature:
ALU_ACCUM_EN
- Defined: on enter_rise in S_RES, A <= result and the FSM goes to S_B, giving chained operations. A reset is the only way back to S_A.
- Undefined: S_RES -> S_A as specified above.

Decomposition:
- Package alu_calc_pkg holds:
  - state_t enum {S_A, S_B, S_OP, S_RES};
  - op_t enum with the 8 opcodes;
  - flag index localparams FLAG_N=4, FLAG_Z=3, FLAG_C=2, FLAG_V=1, FLAG_P=0.
- Sub-module alu_core_n: combinational, parametrised by N; inputs A, B, op; outputs R and flags. The top holds the FSM, edge detector, registers and display mux.

Test Plan (N=7):
- A=25, B=17, op=ADD -> result=42 (0x2A), flags=5'b00000, result_valid=1 one clock after the third enter rise. display_value=0x3000002A.
- A=100, B=50, ADD -> result=22, flags=5'b00100 (C=1). A=60, B=5, ADD -> result=65, flags=5'b10011 (N=1, V=1, P=1).
- A=9, B=9, SUB -> result=0, flags=5'b01101 (Z=1, C=1, P=1).
- enter held high for 20 cycles in S_A -> exactly one advance to S_B. Toggling data_in afterwards leaves A unchanged.
- Assert reset in S_OP with A=5, B=3 loaded -> state=S_A, result=0, flags=0, result_valid=0 immediately, without waiting for a clock edge. enter held through reset -> no advance until it is released and pressed again.
- ALU_ACCUM_EN defined: 25+17 -> 42; enter in S_RES -> state=S_B, A=42; B=8, ADD -> result=50.

Source files
------------

// File: rtl/alu_calc_pkg.sv
// Shared types and constants for the sequential ALU calculator.
//   state_t : entry FSM states (S_A, S_B, S_OP, S_RES)
//   op_t    : 3-bit opcode encoding
//   FLAG_*  : bit positions inside the 5-bit {N,Z,C,V,P} flag vector
package alu_calc_pkg;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RES = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL1 = 3'd5,
    OP_SHR1 = 3'd6,
    OP_NOT  = 3'd7
  } op_t;

  localparam int unsigned FLAG_N = 4;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_P = 0;

endpackage

// File: rtl/alu_core_n.sv
// Combinational N-bit ALU core.
//   a, b  : operands (N bits)
//   op    : opcode (op_t)
//   r     : result (N bits)
//   flags : {N,Z,C,V,P}; P = even number of ones in r
module alu_core_n
  import alu_calc_pkg::*;
#(
  parameter int N = 7
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  op_t          op,
  output logic [N-1:0] r,
  output logic [4:0]   flags
);

  logic [N:0] sum;
  logic       c;
  logic       v;

  always_comb begin
    sum   = '0;
    r     = '0;
    c     = 1'b0;
    v     = 1'b0;
    flags = '0;
    unique case (op)
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[N-1:0];
        c   = sum[N];
        v   = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      OP_SUB: begin
        // Two's complement subtract; carry out set means no borrow (a >= b).
        sum = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        r   = sum[N-1:0];
        c   = sum[N];
        v   = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SHL1: begin
        r = {a[N-2:0], 1'b0};
        c = a[N-1];
      end
      OP_SHR1: begin
        r = {1'b0, a[N-1:1]};
        c = a[0];
      end
      OP_NOT:  r = ~a;
      default: r = '0;
    endcase
    flags[FLAG_N] = r[N-1];
    flags[FLAG_Z] = (r == '0);
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
    flags[FLAG_P] = ~^r;
  end

endmodule

// File: rtl/alu_seq_calc.sv
// Sequential ALU calculator: A, B and opcode are entered in turn on a shared
// switch bus, each committed by a rising edge of the debounced `enter` level.
//   clock, reset  : clock, asynchronous active-high reset
//   data_in       : operand switches (N bits)
//   op_sel        : opcode switches (OP_W bits)
//   enter         : debounced button level
//   result, flags : registered ALU result and {N,Z,C,V,P}
//   result_valid  : high while in S_RES
//   state_out     : current FSM state
//   display_value : {2'b00, state, zero pad, N-bit shown value}
// Optional macro ALU_ACCUM_EN: S_RES chains into S_B with A <= result.
module alu_seq_calc
  import alu_calc_pkg::*;
#(
  parameter int N    = 7,
  parameter int OP_W = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    data_in,
  input  logic [OP_W-1:0] op_sel,
  input  logic            enter,
  output logic [N-1:0]    result,
  output logic [4:0]      flags,
  output logic            result_valid,
  output logic [1:0]      state_out,
  output logic [31:0]     display_value
);

  // Keeps any opcode bits above N out of the [27:N] padding.
  localparam logic [27:0] LOW_MASK = 28'((29'd1 << N) - 29'd1);

  state_t      state;
  logic [N-1:0] a_reg;
  logic [N-1:0] b_reg;
  logic [N-1:0] alu_r;
  logic [4:0]   alu_flags;
  logic         enter_q;
  logic         enter_rise;
  logic [27:0]  shown;

  assign enter_rise = enter & ~enter_q;

  alu_core_n #(.N(N)) u_core (
    .a    (a_reg),
    .b    (b_reg),
    .op   (op_t'(op_sel)),
    .r    (alu_r),
    .flags(alu_flags)
  );

  // enter_q resets high so a button held through reset is not a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_A;
      a_reg        <= '0;
      b_reg        <= '0;
      result       <= '0;
      flags        <= '0;
      result_valid <= 1'b0;
      enter_q      <= 1'b1;
    end else begin
      enter_q <= enter;
      if (enter_rise) begin
        unique case (state)
          S_A: begin
            a_reg <= data_in;
            state <= S_B;
          end
          S_B: begin
            b_reg <= data_in;
            state <= S_OP;
          end
          S_OP: begin
            result       <= alu_r;
            flags        <= alu_flags;
            result_valid <= 1'b1;
            state        <= S_RES;
          end
          S_RES: begin
            result_valid <= 1'b0;
`ifdef ALU_ACCUM_EN
            a_reg <= result;
            state <= S_B;
`else
            state <= S_A;
`endif
          end
          default: state <= S_A;
        endcase
      end
    end
  end

  always_comb begin
    shown = '0;
    unique case (state)
      S_A, S_B: shown = 28'(data_in);
      S_OP:     shown = 28'(op_sel) & LOW_MASK;
      S_RES:    shown = 28'(result);
      default:  shown = '0;
    endcase
    display_value = {2'b00, state, shown};
  end

  assign state_out = state;

endmodule

// File: tb/tb_alu_seq_calc.sv
module tb_alu_seq_calc;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  data_in;
  logic [2:0]  op_sel;
  logic        enter;
  logic [6:0]  result;
  logic [4:0]  flags;
  logic        result_valid;
  logic [1:0]  state_out;
  logic [31:0] display_value;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];   // {result, flags}

  alu_seq_calc #(.N(7), .OP_W(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .op_sel       (op_sel),
    .enter        (enter),
    .result       (result),
    .flags        (flags),
    .result_valid (result_valid),
    .state_out    (state_out),
    .display_value(display_value)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model in integer/signed arithmetic terms.
  function automatic logic [11:0] model(input int a, input int b, input int op);
    int r, c, v, sa, sb, s;
    c = 0; v = 0;
    sa = (a >= 64) ? a - 128 : a;
    sb = (b >= 64) ? b - 128 : b;
    case (op)
      0: begin r = (a + b) % 128; c = (a + b >= 128); s = sa + sb; v = (s > 63 || s < -64); end
      1: begin r = (a - b + 128) % 128; c = (a >= b); s = sa - sb; v = (s > 63 || s < -64); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a * 2) % 128; c = (a >= 64); end
      6: begin r = a / 2; c = a % 2; end
      default: r = 127 - a;
    endcase
    return {7'(r), (r >= 64) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0, 1'(c), 1'(v),
            ($countones(7'(r)) % 2 == 0) ? 1'b1 : 1'b0};
  endfunction

  task automatic press(input logic [6:0] v);
    data_in = v;
    @(negedge clock); enter = 1'b1;
    @(negedge clock); enter = 1'b0;
    @(negedge clock);
  endtask

  // Scoreboard pop when result_valid appears (bounded wait).
  task automatic collect(input string tag);
    logic [11:0] e;
    int n;
    n = 0;
    while (!result_valid && n < 8) begin @(negedge clock); n++; end
    if (!result_valid) begin
      check_val({tag, "_timeout"}, 32'(result_valid), 32'd1);
    end else if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_res"}, 32'(result), 32'(e[11:5]));
      check_val({tag, "_flg"}, 32'(flags), 32'(e[4:0]));
      check_val({tag, "_disp"}, display_value, 32'h3000_0000 | 32'(e[11:5]));
    end
  endtask

  task automatic calc(input string tag, input int a, input int b, input int op);
    press(7'(a));
    press(7'(b));
    op_sel = 3'(op);
    exp_q.push_back(model(a, b, op));
    press(7'h00);
    collect(tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    reset = 1'b1; enter = 1'b0; data_in = '0; op_sel = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_val("rst_state", 32'(state_out), 32'd0);
    check_val("rst_res", 32'(result), 32'd0);
    check_val("rst_flg", 32'(flags), 32'd0);
    check_val("rst_rv", 32'(result_valid), 32'd0);
    data_in = 7'h55; #1;
    check_val("disp_live_a", display_value, 32'h0000_0055);

    // Held enter: one advance only; later data_in changes must not touch A.
    data_in = 7'd11;
    @(negedge clock); enter = 1'b1;
    repeat (20) @(negedge clock);
    check_val("hold_state", 32'(state_out), 32'd1);
    enter = 1'b0;
    data_in = 7'd99; @(negedge clock);
    data_in = 7'd120; @(negedge clock);
    check_val("disp_live_b", display_value, 32'h1000_0078);
    press(7'd3);
    op_sel = 3'd2;
    #1 check_val("disp_op", display_value, 32'h2000_0002);
    exp_q.push_back(model(11, 3, 2));
    press(7'h00);
    collect("hold_and");

    // Load A=5,B=3 then reset asynchronously in S_OP with enter held.
`ifdef ALU_ACCUM_EN
    press(7'd0);   // S_RES -> S_B, A <= 3
    press(7'd3);
`else
    press(7'd0);   // S_RES -> S_A
    press(7'd5);
    press(7'd3);
`endif
    check_val("pre_rst_state", 32'(state_out), 32'd2);
    enter = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_val("arst_state", 32'(state_out), 32'd0);
    check_val("arst_res", 32'(result), 32'd0);
    check_val("arst_flg", 32'(flags), 32'd0);
    check_val("arst_rv", 32'(result_valid), 32'd0);
    @(negedge clock); reset = 1'b0;
    repeat (3) @(negedge clock);
    check_val("held_thru_rst", 32'(state_out), 32'd0);
    enter = 1'b0;
    @(negedge clock);
    press(7'd1);
    check_val("repress", 32'(state_out), 32'd1);
    reset = 1'b1; @(negedge clock); reset = 1'b0; @(negedge clock);

`ifdef ALU_ACCUM_EN
    calc("acc_add", 25, 17, 0);
    press(7'd0);
    check_val("acc_state", 32'(state_out), 32'd1);
    op_sel = 3'd0;
    exp_q.push_back(model(42, 8, 0));
    press(7'd8);
    press(7'd0);
    collect("acc_chain");
`else
    calc("add_25_17", 25, 17, 0);
    press(7'd0);
    check_val("back_to_a", 32'(state_out), 32'd0);
    calc("add_carry", 100, 50, 0);
    press(7'd0);
    calc("add_ovf", 60, 5, 0);
    press(7'd0);
    calc("sub_zero", 9, 9, 1);
    press(7'd0);
    calc("sub_borrow", 3, 9, 1);
    press(7'd0);
    calc("shl_msb", 64, 0, 5);
    press(7'd0);
    calc("shr_lsb", 1, 0, 6);
    press(7'd0);
    for (int i = 0; i < 16; i++) begin
      calc("rand", int'($urandom_range(127)), int'($urandom_range(127)), i % 8);
      press(7'd0);
    end
    check_val("final_state", 32'(state_out), 32'd0);
`endif
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
